// File: rtl/usb_hs_rx_deser.sv
// rtl/usb_hs_rx_deser.sv - HS RX deserializer: NRZI decode, SYNC hunt, bit unstuffing, byte assembly, EOP/error detect
// Optional babble length limit is compiled in when USB_HS_RX_BABBLE_EN is defined.
module usb_hs_rx_deser #(
    parameter int SYNC_MIN_ZEROS = 12,
    parameter int MAX_BYTES      = 1027
) (
    input  logic       clk_datarx,
    input  logic       rst_n,
    input  logic       rx_enable,
    input  logic       squelch,
    input  logic       hs_bit_phy,
    output logic       rx_active,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_eop,
    output logic       rx_error
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [4:0] SYNC_MIN_C = 5'(SYNC_MIN_ZEROS);

    if (SYNC_MIN_ZEROS < 4 || SYNC_MIN_ZEROS > 31 || MAX_BYTES < 1 || MAX_BYTES > 2047) begin : g_bad_params
        $error("usb_hs_rx_deser: SYNC_MIN_ZEROS or MAX_BYTES out of range");
    end

    state_t     state_q, state_d;
    logic       prev_line_q;
    logic [4:0] zero_cnt_q, zero_cnt_d;
    logic [2:0] ones_cnt_q, ones_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] sreg_q, sreg_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_active_q, rx_active_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_eop_q, rx_eop_d;
    logic       rx_error_q, rx_error_d;

`ifdef USB_HS_RX_BABBLE_EN
    localparam logic [10:0] MAX_BYTES_C = 11'(MAX_BYTES);
    logic [10:0] byte_cnt_q, byte_cnt_d;
`endif

    logic       d_bit;
    logic       stuff_slot;
    logic [2:0] ones_inc;
    logic [4:0] zero_inc;
    logic [7:0] byte_next;

    assign d_bit      = (hs_bit_phy == prev_line_q);
    assign stuff_slot = (ones_cnt_q == 3'd6);
    assign ones_inc   = (ones_cnt_q == 3'd7) ? 3'd7 : ones_cnt_q + 3'd1;
    assign zero_inc   = (zero_cnt_q == 5'd31) ? 5'd31 : zero_cnt_q + 5'd1;
    assign byte_next  = {d_bit, sreg_q[7:1]};

    always_comb begin
        state_d     = state_q;
        zero_cnt_d  = '0;
        ones_cnt_d  = d_bit ? ones_inc : 3'd0;
        bit_cnt_d   = bit_cnt_q;
        sreg_d      = sreg_q;
        rx_data_d   = rx_data_q;
        rx_active_d = rx_active_q;
        rx_valid_d  = 1'b0;
        rx_eop_d    = 1'b0;
        rx_error_d  = 1'b0;
`ifdef USB_HS_RX_BABBLE_EN
        byte_cnt_d  = byte_cnt_q;
`endif

        if (!rx_enable) begin
            // Forced idle is silent: the packet just disappears downstream.
            state_d     = ST_IDLE;
            rx_active_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rx_active_d = 1'b0;
                    if (squelch) begin
                        zero_cnt_d = '0;
                    end else if (!d_bit) begin
                        zero_cnt_d = zero_inc;
                    end else if (zero_cnt_q >= SYNC_MIN_C) begin
                        state_d     = ST_DATA;
                        rx_active_d = 1'b1;
                        ones_cnt_d  = 3'd0;
                        bit_cnt_d   = 3'd0;
                        sreg_d      = '0;
`ifdef USB_HS_RX_BABBLE_EN
                        byte_cnt_d  = '0;
`endif
                    end
                end

                ST_DATA: begin
                    if (squelch) begin
                        rx_error_d  = 1'b1;
                        rx_active_d = 1'b0;
                        state_d     = ST_WAIT;
                    end else if (stuff_slot) begin
                        // A 1 where a stuff 0 belongs ends the packet; only a byte-aligned one is a clean EOP.
                        if (d_bit) begin
                            rx_eop_d    = (bit_cnt_q == 3'd7);
                            rx_error_d  = (bit_cnt_q != 3'd7);
                            rx_active_d = 1'b0;
                            state_d     = ST_WAIT;
                        end
                    end else begin
                        sreg_d    = byte_next;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef USB_HS_RX_BABBLE_EN
                            if (byte_cnt_q == MAX_BYTES_C) begin
                                rx_error_d  = 1'b1;
                                rx_active_d = 1'b0;
                                state_d     = ST_WAIT;
                            end else begin
                                rx_data_d  = byte_next;
                                rx_valid_d = 1'b1;
                                byte_cnt_d = byte_cnt_q + 11'd1;
                            end
`else
                            rx_data_d  = byte_next;
                            rx_valid_d = 1'b1;
`endif
                        end
                    end
                end

                ST_WAIT: begin
                    // Hold off re-SYNC until the line has gone quiet, so the EOP tail is never mistaken for SYNC.
                    rx_active_d = 1'b0;
                    if (squelch) begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d     = ST_IDLE;
                    rx_active_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_datarx or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            prev_line_q <= 1'b1;
            zero_cnt_q  <= '0;
            ones_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            sreg_q      <= '0;
            rx_data_q   <= '0;
            rx_active_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_eop_q    <= 1'b0;
            rx_error_q  <= 1'b0;
`ifdef USB_HS_RX_BABBLE_EN
            byte_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            prev_line_q <= hs_bit_phy;
            zero_cnt_q  <= zero_cnt_d;
            ones_cnt_q  <= ones_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            sreg_q      <= sreg_d;
            rx_data_q   <= rx_data_d;
            rx_active_q <= rx_active_d;
            rx_valid_q  <= rx_valid_d;
            rx_eop_q    <= rx_eop_d;
            rx_error_q  <= rx_error_d;
`ifdef USB_HS_RX_BABBLE_EN
            byte_cnt_q  <= byte_cnt_d;
`endif
        end
    end

    assign rx_active = rx_active_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;
    assign rx_eop    = rx_eop_q;
    assign rx_error  = rx_error_q;

endmodule
